// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
// Shared constants and types for the NfiVe32 integer register file.
//   RF_DATA_W    : width of one architectural register
//   RF_ADDR_W    : width of a register address (x0..x31)
//   RF_DEPTH     : number of architectural registers
//   RF_ZERO_ADDR : address of the hardwired-zero register x0
//   rf_addr_t    : register address type
//   rf_data_t    : register data type
//   rfIsZeroAddr : helper that flags the hardwired-zero address
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int RF_DEPTH  = 2 ** RF_ADDR_W;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  localparam rf_addr_t RF_ZERO_ADDR = '0;

  // True when an address names x0, whose reads are always zero and whose
  // writes are discarded.
  function automatic logic rfIsZeroAddr(input rf_addr_t addr);
    return (addr == RF_ZERO_ADDR);
  endfunction

endpackage : regfile_pkg

// File: rtl/regfile_word.sv
// ---------------------------------------------------------------------------
// regfile_word
// One architectural register: a DATA_W-bit flop bank with synchronous
// active-high reset and a load enable. Kept as its own module so that each
// register has a single, isolated enable that a clock-gating flow can pick up.
// Ports:
//   i_clk   : clock, state changes on the rising edge
//   i_reset : synchronous active-high clear, wins over i_load
//   i_load  : capture i_d on the next rising edge
//   i_d     : data to capture
//   o_q     : current register contents
// ---------------------------------------------------------------------------
module regfile_word #(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  // Reset is checked first so a write issued in the same cycle as reset is
  // dropped; without load the register simply holds its value.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : regfile_word

// File: rtl/regfile.sv
// ---------------------------------------------------------------------------
// regfile
// 32 x 32-bit integer register file for the NfiVe32 RV32 datapath, sitting
// between decode (which supplies RA/RB/RW) and execute/writeback.
// Two combinational read ports and one synchronous write port; x0 is
// hardwired to zero. There is no write-through bypass: a read of the
// register being written returns the old value until the write edge.
// Ports:
//   HCLK   : clock, all state updates on the rising edge
//   HRESET : synchronous active-high reset, clears every register
//   WR     : write enable
//   RA     : read port A address
//   RB     : read port B address
//   RW     : write address
//   DW     : write data
//   DA     : read port A data, reg[RA]
//   DB     : read port B data, reg[RB]
// ---------------------------------------------------------------------------
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              WR,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RW,
  input  logic [DATA_W-1:0] DW,
  output logic [DATA_W-1:0] DA,
  output logic [DATA_W-1:0] DB
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Current value of every architectural register; entry 0 is constant zero.
  logic [DATA_W-1:0] w_regs [DEPTH];

  // One-hot write enables for x1..x31. There is no enable for x0, so
  // writes addressed to x0 are discarded by construction.
  logic [DEPTH-1:1] w_wrEn;

  // x0 has no storage at all; it reads zero even before the first reset.
  assign w_regs[0] = '0;

  // Build x1..x31, each with its own decoded load enable.
  for (genvar gi = 1; gi < DEPTH; gi++) begin : g_word
    assign w_wrEn[gi] = WR && (RW == ADDR_W'(gi));

    regfile_word #(
      .DATA_W (DATA_W)
    ) u_word (
      .i_clk   (HCLK),
      .i_reset (HRESET),
      .i_load  (w_wrEn[gi]),
      .i_d     (DW),
      .o_q     (w_regs[gi])
    );
  end : g_word

  // The two read ports are plain DEPTH:1 multiplexers over the register
  // outputs, so an address change shows up on DA/DB in the same cycle and a
  // freshly written value appears straight after the write edge.
  always_comb begin
    DA = w_regs[RA];
    DB = w_regs[RB];
  end

endmodule : regfile

// File: tb/tb_regfile.sv
// ---------------------------------------------------------------------------
// tb_regfile
// Directed testbench for regfile. Each cycle the stimulus process drives the
// inputs just after the rising edge and pushes the read-port values it
// expects for that cycle into a scoreboard queue; a monitor process samples
// DA/DB on the falling edge and pops and compares every pending entry.
// ---------------------------------------------------------------------------
module tb_regfile;

  logic        HCLK;
  logic        HRESET;
  logic        WR;
  logic [4:0]  RA;
  logic [4:0]  RB;
  logic [4:0]  RW;
  logic [31:0] DW;
  logic [31:0] DA;
  logic [31:0] DB;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct {
    string       name;
    logic [31:0] expA;
    logic [31:0] expB;
    bit          chkA;
    bit          chkB;
  } exp_t;

  exp_t scoreQ[$];

  regfile dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .WR     (WR),
    .RA     (RA),
    .RB     (RB),
    .RW     (RW),
    .DW     (DW),
    .DA     (DA),
    .DB     (DB)
  );

  // Free-running 10 ns clock.
  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  // Hard stop in case anything stalls the stimulus process.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired: got timeout, required normal completion");
    $fatal(1, "[TB] watchdog");
  end

  // Drive one cycle's worth of inputs just after the rising edge; they are
  // then sampled by the DUT on the following rising edge.
  task automatic applyStimulus(input logic rst, input logic wr,
                               input logic [4:0] rw, input logic [31:0] dw,
                               input logic [4:0] ra, input logic [4:0] rb);
    @(posedge HCLK);
    #1;
    HRESET = rst;
    WR     = wr;
    RW     = rw;
    DW     = dw;
    RA     = ra;
    RB     = rb;
  endtask

  // Queue the read-port values expected during the current cycle.
  task automatic checkOutput(input string nm, input logic [31:0] ea,
                             input logic [31:0] eb, input bit ca, input bit cb);
    exp_t e;
    e.name = nm;
    e.expA = ea;
    e.expB = eb;
    e.chkA = ca;
    e.chkB = cb;
    scoreQ.push_back(e);
  endtask

  // Monitor: on each falling edge compare the read ports with every
  // expectation queued for this cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge HCLK);
      while (scoreQ.size() > 0) begin
        e = scoreQ.pop_front();
        if (e.chkA) begin
          checkCount++;
          if (DA !== e.expA) begin
            errorCount++;
            $display("[TB] FAIL %s DA: got %08h required %08h", e.name, DA, e.expA);
          end
        end
        if (e.chkB) begin
          checkCount++;
          if (DB !== e.expB) begin
            errorCount++;
            $display("[TB] FAIL %s DB: got %08h required %08h", e.name, DB, e.expB);
          end
        end
      end
    end
  end

  // Stimulus sequence with hand-computed expectations.
  initial begin
    HRESET = 1'b1;
    WR     = 1'b0;
    RW     = '0;
    DW     = '0;
    RA     = '0;
    RB     = '0;

    // Reset for one cycle, then read back zeros.
    applyStimulus(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd10);
    checkOutput("reset_read", 32'h0, 32'h0, 1'b1, 1'b1);

    // Write x5; before the edge the old value (0) is still visible.
    applyStimulus(1'b0, 1'b1, 5'd5, 32'h0000_0064, 5'd5, 5'd10);
    checkOutput("pre_write_x5", 32'h0, 32'h0, 1'b1, 1'b1);

    // Write x10 while reading back x5.
    applyStimulus(1'b0, 1'b1, 5'd10, 32'h0000_00C8, 5'd5, 5'd10);
    checkOutput("read_x5", 32'h0000_0064, 32'h0, 1'b1, 1'b1);

    // Hold a write to x20 for ten edges.
    applyStimulus(1'b0, 1'b1, 5'd20, 32'hFFFB_6BC2, 5'd20, 5'd10);
    checkOutput("pre_write_x20", 32'h0, 32'h0000_00C8, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b1, 5'd20, 32'hFFFB_6BC2, 5'd20, 5'd10);
      checkOutput("hold_x20", 32'hFFFB_6BC2, 32'h0000_00C8, 1'b1, 1'b1);
    end

    // Overwrite x20; the last edge wins.
    applyStimulus(1'b0, 1'b1, 5'd20, 32'h0000_0383, 5'd20, 5'd10);
    checkOutput("pre_overwrite_x20", 32'hFFFB_6BC2, 32'h0000_00C8, 1'b1, 1'b1);

    // Write disabled: nothing changes whatever RW/DW hold.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 5'd20, 32'h8070_0383, 5'd20, 5'd10);
      checkOutput("wr_disabled", 32'h0000_0383, 32'h0000_00C8, 1'b1, 1'b1);
    end

    // Attempted write to x0.
    applyStimulus(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0, 5'd10);
    checkOutput("pre_write_x0", 32'h0, 32'h0000_00C8, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd5);
    checkOutput("x0_after_write", 32'h0, 32'h0000_0064, 1'b1, 1'b1);

    // Same address on both ports.
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    checkOutput("same_addr", 32'h0000_0064, 32'h0000_0064, 1'b1, 1'b1);

    // Top address decode: write x31, x1 must stay untouched.
    applyStimulus(1'b0, 1'b1, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd1);
    checkOutput("pre_write_x31", 32'h0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd1, 32'h1111_1111, 5'd31, 5'd1);
    checkOutput("read_x31", 32'hCAFE_F00D, 32'h0, 1'b1, 1'b1);

    // Give x7 a nonzero value so reset priority is observable.
    applyStimulus(1'b0, 1'b1, 5'd7, 32'h1111_1111, 5'd7, 5'd5);
    checkOutput("pre_write_x7", 32'h0, 32'h0000_0064, 1'b1, 1'b1);

    // Reset and write on the same edge: reset wins.
    applyStimulus(1'b1, 1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd5);
    checkOutput("pre_reset", 32'h1111_1111, 32'h0000_0064, 1'b1, 1'b1);

    // Read-during-write on x7 after the reset.
    applyStimulus(1'b0, 1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd5);
    checkOutput("reset_priority", 32'h0, 32'h0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 5'd7, 32'h0, 5'd7, 5'd20);
    checkOutput("rdw_after_edge", 32'hA5A5_A5A5, 32'h0, 1'b1, 1'b1);

    // Let the monitor drain the queue, bounded to a few cycles.
    for (int i = 0; i < 4 && scoreQ.size() > 0; i++) begin
      @(negedge HCLK);
    end
    #1;
    if (scoreQ.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL drain: got %0d pending, required 0", scoreQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule : tb_regfile
